// File: rtl/mmio_fifo_ctrl_pkg.sv
// Shared constants for the MMIO FIFO controller: register map, STATUS/CTRL bit positions
// and the address decoder.
package mmio_fifo_pkg;

  localparam logic [15:0] DATA_OFS   = 16'd0;
  localparam logic [15:0] CTRL_OFS   = 16'd2;
  localparam logic [15:0] STATUS_OFS = 16'd4;
  localparam logic [15:0] THRESH_OFS = 16'd6;

  localparam int ST_EMPTY     = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVF       = 2;
  localparam int ST_UDF       = 3;
  localparam int ST_AFULL     = 4;
  localparam int ST_COUNT_LSB = 16;
  localparam int ST_SIG_LSB   = 48;

  localparam logic [15:0] STATUS_SIG = 16'hF1F0;

  localparam int CTRL_FLUSH = 0;
  localparam int CTRL_CLR   = 1;

  typedef enum logic [2:0] {
    REG_NONE   = 3'd0,
    REG_DATA   = 3'd1,
    REG_CTRL   = 3'd2,
    REG_STATUS = 3'd3,
    REG_THRESH = 3'd4
  } reg_sel_e;

  function automatic reg_sel_e reg_decode(input logic [15:0] addr, input logic [15:0] base);
    reg_sel_e sel;
    if (addr == base + DATA_OFS) sel = REG_DATA;
    else if (addr == base + CTRL_OFS) sel = REG_CTRL;
    else if (addr == base + STATUS_OFS) sel = REG_STATUS;
    else if (addr == base + THRESH_OFS) sel = REG_THRESH;
    else sel = REG_NONE;
    return sel;
  endfunction

endpackage

// File: rtl/mmio_fifo_ctrl_if.sv
// MMIO request/response bundle between the AFU MMIO decoder (master) and the FIFO controller (slave).
interface mmio_fifo_ctrl_if;
  logic        mmio_wr_valid;
  logic        mmio_rd_valid;
  logic [15:0] mmio_addr;
  logic [8:0]  mmio_tid;
  logic [63:0] mmio_wdata;
  logic        rsp_valid;
  logic [8:0]  rsp_tid;
  logic [63:0] rsp_data;
  logic        hit;

  modport master (
    output mmio_wr_valid, mmio_rd_valid, mmio_addr, mmio_tid, mmio_wdata,
    input  rsp_valid, rsp_tid, rsp_data, hit
  );

  modport slave (
    input  mmio_wr_valid, mmio_rd_valid, mmio_addr, mmio_tid, mmio_wdata,
    output rsp_valid, rsp_tid, rsp_data, hit
  );
endinterface

// File: rtl/mmio_fifo_ctrl_sync_fifo.sv
// Show-ahead synchronous FIFO: dout always presents the head entry; flush overrides push and pop.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full  = (count_r == (AW+1)'(DEPTH));
  assign empty = (count_r == (AW+1)'(0));
  assign count = count_r;
  assign dout  = mem_r[rd_ptr_r];

  // Qualify requests: a full FIFO still takes a push when a pop frees a slot this cycle.
  always_comb begin
    do_pop_s  = pop && !empty && !flush;
    do_push_s = push && !flush && (!full || (pop && !empty));
  end

  // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= (AW+1)'(0);
    end else if (flush) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= (AW+1)'(0);
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (do_pop_s) rd_ptr_r <= rd_ptr_r + AW'(1);
      if (do_push_s && !do_pop_s) count_r <= count_r + (AW+1)'(1);
      else if (do_pop_s && !do_push_s) count_r <= count_r - (AW+1)'(1);
    end
  end

  // Storage array, intentionally left unreset.
  always_ff @(posedge clk) begin
    if (do_push_s) mem_r[wr_ptr_r] <= din;
  end
endmodule

// File: rtl/mmio_fifo_ctrl.sv
// Host MMIO front end for a show-ahead FIFO: DATA push/pop, CTRL flush/clear, STATUS and THRESH,
// with a one-cycle registered read response.
module mmio_fifo_ctrl
  import mmio_fifo_pkg::*;
#(
  parameter int          DEPTH     = 16,
  parameter int          WIDTH     = 64,
  parameter logic [15:0] BASE_ADDR = 16'h0020
) (
  input  logic             clk,
  input  logic             rst_n,
  mmio_fifo_ctrl_if.slave  bus,
  output logic             almost_full
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] head_s;
  logic [AW:0]      count_s;
  logic [AW:0]      thresh_r;
  logic [AW:0]      thresh_in_s;
  logic             full_s, empty_s;
  logic             ovf_r, udf_r, afull_r;
  logic             rsp_valid_r;
  logic [8:0]       rsp_tid_r;
  logic [63:0]      rsp_data_r;
  logic [63:0]      rd_mux_s;
  logic [63:0]      status_s;
  reg_sel_e         sel_s;
  logic             rd_hit_s, wr_data_s, rd_data_s, flush_s, clr_s;
  logic             ovf_set_s, udf_set_s, thresh_wr_s;

  sync_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (wr_data_s),
    .pop   (rd_data_s),
    .flush (flush_s),
    .din   (bus.mmio_wdata[WIDTH-1:0]),
    .dout  (head_s),
    .count (count_s),
    .full  (full_s),
    .empty (empty_s)
  );

  // Decode, flag events, THRESH saturation and read-data selection, all from pre-cycle state.
  always_comb begin
    sel_s       = reg_decode(bus.mmio_addr, BASE_ADDR);
    rd_hit_s    = bus.mmio_rd_valid && (sel_s != REG_NONE);
    wr_data_s   = bus.mmio_wr_valid && (sel_s == REG_DATA);
    rd_data_s   = bus.mmio_rd_valid && (sel_s == REG_DATA);
    flush_s     = bus.mmio_wr_valid && (sel_s == REG_CTRL) && bus.mmio_wdata[CTRL_FLUSH];
    clr_s       = bus.mmio_wr_valid && (sel_s == REG_CTRL) && bus.mmio_wdata[CTRL_CLR];
    thresh_wr_s = bus.mmio_wr_valid && (sel_s == REG_THRESH);
    ovf_set_s   = wr_data_s && full_s && !rd_data_s && !flush_s;
    udf_set_s   = rd_data_s && empty_s;
    if (bus.mmio_wdata[AW:0] > (AW+1)'(DEPTH)) thresh_in_s = (AW+1)'(DEPTH);
    else thresh_in_s = bus.mmio_wdata[AW:0];

    status_s                       = 64'h0;
    status_s[ST_EMPTY]             = empty_s;
    status_s[ST_FULL]              = full_s;
    status_s[ST_OVF]               = ovf_r;
    status_s[ST_UDF]               = udf_r;
    status_s[ST_AFULL]             = afull_r;
    status_s[ST_COUNT_LSB +: 16]   = 16'(count_s);
    status_s[ST_SIG_LSB +: 16]     = STATUS_SIG;

    case (sel_s)
      REG_DATA:   rd_mux_s = empty_s ? 64'h0 : 64'(head_s);
      REG_STATUS: rd_mux_s = status_s;
      REG_THRESH: rd_mux_s = 64'(thresh_r);
      REG_CTRL:   rd_mux_s = 64'h0;
      default:    rd_mux_s = 64'h0;
    endcase
  end

  // Response register, sticky flags (set beats clear), threshold and lagging almost-full.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid_r <= 1'b0;
      rsp_tid_r   <= 9'h0;
      rsp_data_r  <= 64'h0;
      ovf_r       <= 1'b0;
      udf_r       <= 1'b0;
      thresh_r    <= (AW+1)'(DEPTH - 1);
      afull_r     <= 1'b0;
    end else begin
      rsp_valid_r <= rd_hit_s;
      if (rd_hit_s) begin
        rsp_tid_r  <= bus.mmio_tid;
        rsp_data_r <= rd_mux_s;
      end
      if (ovf_set_s) ovf_r <= 1'b1;
      else if (clr_s) ovf_r <= 1'b0;
      if (udf_set_s) udf_r <= 1'b1;
      else if (clr_s) udf_r <= 1'b0;
      if (thresh_wr_s) thresh_r <= thresh_in_s;
      afull_r <= (count_s >= thresh_r);
    end
  end

  assign bus.hit       = (bus.mmio_wr_valid || bus.mmio_rd_valid) && (sel_s != REG_NONE);
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_tid   = rsp_tid_r;
  assign bus.rsp_data  = rsp_data_r;
  assign almost_full   = afull_r;
endmodule

// File: tb/tb_mmio_fifo_ctrl.sv
// Bench for mmio_fifo_ctrl: directed vector table, reset corner sequences, then random
// traffic checked against a queue-based register model.
module tb_mmio_fifo_ctrl;
  localparam int          DEPTH  = 16;
  localparam logic [15:0] BASE   = 16'h0020;
  localparam logic [15:0] A_DATA = BASE;
  localparam logic [15:0] A_CTRL = BASE + 16'd2;
  localparam logic [15:0] A_STAT = BASE + 16'd4;
  localparam logic [15:0] A_THR  = BASE + 16'd6;

  logic clk = 1'b0;
  logic rst_n;
  logic almost_full;
  mmio_fifo_ctrl_if bus();

  mmio_fifo_ctrl #(.DEPTH(DEPTH), .WIDTH(64), .BASE_ADDR(BASE)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.slave),
    .almost_full (almost_full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [15:0] addr;
    logic [63:0] wd;
    logic        rsp;
    logic [63:0] exp;
    logic        hit;
  } vec_t;

  vec_t        vecs[$];
  int          tests = 0;
  int          failed = 0;
  logic        rv, hs;
  logic [8:0]  rt;
  logic [63:0] rdat;

  logic [63:0] mq[$];
  logic        m_ovf, m_udf, m_af;
  int          m_thr;

  function automatic void add(input logic wr, input logic rd, input logic [15:0] a,
                              input logic [63:0] wd, input logic rsp, input logic [63:0] exp,
                              input logic hit);
    vec_t v;
    v.wr = wr; v.rd = rd; v.addr = a; v.wd = wd; v.rsp = rsp; v.exp = exp; v.hit = hit;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: actual %h required %h", nm, act, exp);
    end
  endtask

  // Drive one request for one cycle; hit is sampled mid-cycle, the response after the edge.
  task automatic step(input logic wr, input logic rd, input logic [15:0] a,
                      input logic [8:0] tid, input logic [63:0] wd);
    bus.mmio_wr_valid = wr;
    bus.mmio_rd_valid = rd;
    bus.mmio_addr     = a;
    bus.mmio_tid      = tid;
    bus.mmio_wdata    = wd;
    #1 hs = bus.hit;
    @(posedge clk);
    @(negedge clk);
    bus.mmio_wr_valid = 1'b0;
    bus.mmio_rd_valid = 1'b0;
    rv   = bus.rsp_valid;
    rt   = bus.rsp_tid;
    rdat = bus.rsp_data;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(1'b0, 1'b0, 16'h0, 9'h0, 64'h0);
    step(1'b0, 1'b0, 16'h0, 9'h0, 64'h0);
    rst_n = 1'b1;
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf = 1'b0; m_udf = 1'b0; m_af = 1'b0; m_thr = DEPTH - 1;
  endtask

  // Register-level reference: occupancy is the queue length, almost_full lags by one request.
  task automatic model_step(input logic wr, input logic rd, input logic [15:0] a,
                            input logic [63:0] wd, output logic e_rv, output logic [63:0] e_d,
                            output logic e_hit);
    logic in_win, af_next;
    int   sz;
    in_win  = (a == A_DATA) || (a == A_CTRL) || (a == A_STAT) || (a == A_THR);
    sz      = mq.size();
    af_next = (sz >= m_thr);
    e_hit   = (wr || rd) && in_win;
    e_rv    = rd && in_win;
    e_d     = 64'h0;
    if (rd && a == A_DATA && sz > 0) e_d = mq[0];
    if (rd && a == A_STAT)
      e_d = {16'hF1F0, 16'h0, 16'(sz), 11'h0, m_af, m_udf, m_ovf, sz == DEPTH, sz == 0};
    if (rd && a == A_THR) e_d = 64'(m_thr);
    if (wr && a == A_CTRL && wd[1]) begin m_ovf = 1'b0; m_udf = 1'b0; end
    if (rd && a == A_DATA && sz == 0) m_udf = 1'b1;
    if (wr && a == A_THR) m_thr = (wd[4:0] > 5'd16) ? DEPTH : int'(wd[4:0]);
    if (wr && a == A_CTRL && wd[0]) mq.delete();
    else begin
      if (rd && a == A_DATA && sz > 0) void'(mq.pop_front());
      if (wr && a == A_DATA) begin
        if (mq.size() < DEPTH) mq.push_back(wd);
        else m_ovf = 1'b1;
      end
    end
    m_af = af_next;
  endtask

  initial begin
    logic        e_rv, e_hit;
    logic [63:0] e_d;

    // Directed table: fill, overflow, drain, underflow, wrap, flush, threshold, decode.
    add(0, 1, A_STAT, 64'h0, 1, 64'hF1F0_0000_0000_0001, 1);
    for (int i = 0; i < 15; i++) add(1, 0, A_DATA, 64'h11 + 64'(i), 0, 64'h0, 1);
    add(0, 1, A_THR,  64'h0, 1, 64'd15, 1);
    add(0, 1, A_STAT, 64'h0, 1, 64'hF1F0_0000_000F_0010, 1);
    add(1, 0, A_DATA, 64'h20, 0, 64'h0, 1);
    add(0, 1, A_STAT, 64'h0, 1, 64'hF1F0_0000_0010_0012, 1);
    add(1, 0, A_DATA, 64'h21, 0, 64'h0, 1);
    add(0, 1, A_STAT, 64'h0, 1, 64'hF1F0_0000_0010_0016, 1);
    for (int i = 0; i < 16; i++) add(0, 1, A_DATA, 64'h0, 1, 64'h11 + 64'(i), 1);
    add(0, 1, A_DATA, 64'h0, 1, 64'h0, 1);
    add(0, 1, A_STAT, 64'h0, 1, 64'hF1F0_0000_0000_000D, 1);
    add(1, 0, A_CTRL, 64'h2, 0, 64'h0, 1);
    add(0, 1, A_STAT, 64'h0, 1, 64'hF1F0_0000_0000_0001, 1);
    for (int i = 0; i < 16; i++) add(1, 0, A_DATA, 64'h11 + 64'(i), 0, 64'h0, 1);
    add(1, 1, A_DATA, 64'hAA, 1, 64'h11, 1);
    add(0, 1, A_STAT, 64'h0, 1, 64'hF1F0_0000_0010_0012, 1);
    for (int i = 0; i < 15; i++) add(0, 1, A_DATA, 64'h0, 1, 64'h12 + 64'(i), 1);
    add(0, 1, A_DATA, 64'h0, 1, 64'hAA, 1);
    add(0, 1, A_STAT, 64'h0, 1, 64'hF1F0_0000_0000_0001, 1);
    add(1, 1, A_DATA, 64'h55, 1, 64'h0, 1);
    add(0, 1, A_STAT, 64'h0, 1, 64'hF1F0_0000_0001_0008, 1);
    add(0, 1, A_DATA, 64'h0, 1, 64'h55, 1);
    add(1, 0, A_CTRL, 64'h2, 0, 64'h0, 1);
    for (int i = 0; i < 3; i++) add(1, 0, A_DATA, 64'h31 + 64'(i), 0, 64'h0, 1);
    add(0, 1, A_DATA, 64'h0, 1, 64'h31, 1);
    add(1, 0, A_CTRL, 64'h1, 0, 64'h0, 1);
    add(0, 1, A_STAT, 64'h0, 1, 64'hF1F0_0000_0000_0001, 1);
    add(1, 0, A_DATA, 64'h44, 0, 64'h0, 1);
    add(1, 0, A_CTRL, 64'h1, 0, 64'h0, 1);
    add(0, 1, A_STAT, 64'h0, 1, 64'hF1F0_0000_0000_0001, 1);
    add(1, 1, A_THR,  64'h3, 1, 64'd15, 1);
    add(0, 1, A_THR,  64'h0, 1, 64'd3, 1);
    add(1, 0, A_THR,  64'h1F, 0, 64'h0, 1);
    add(0, 1, A_THR,  64'h0, 1, 64'd16, 1);
    add(1, 0, A_THR,  64'hFFFF_FFFF_FFFF_FFE0, 0, 64'h0, 1);
    add(0, 1, A_THR,  64'h0, 1, 64'd0, 1);
    add(0, 1, A_STAT, 64'h0, 1, 64'hF1F0_0000_0000_0011, 1);
    add(1, 0, A_THR,  64'd15, 0, 64'h0, 1);
    add(0, 1, 16'h0030, 64'h0, 0, 64'h0, 0);
    add(0, 1, BASE + 16'd1, 64'h0, 0, 64'h0, 0);
    add(1, 0, 16'h0030, 64'h77, 0, 64'h0, 0);
    add(1, 0, A_STAT, 64'hFFFF, 0, 64'h0, 1);
    add(0, 1, A_STAT, 64'h0, 1, 64'hF1F0_0000_0000_0001, 1);
    add(0, 1, A_CTRL, 64'h0, 1, 64'h0, 1);

    bus.mmio_wr_valid = 1'b0;
    bus.mmio_rd_valid = 1'b0;
    bus.mmio_addr     = 16'h0;
    bus.mmio_tid      = 9'h0;
    bus.mmio_wdata    = 64'h0;
    rst_n = 1'b0;
    @(negedge clk);
    do_reset();
    chk("reset rsp_valid", 64'(rv), 64'h0);
    chk("reset rsp_tid", 64'(rt), 64'h0);
    chk("reset rsp_data", rdat, 64'h0);
    chk("reset almost_full", 64'(almost_full), 64'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].wr, vecs[i].rd, vecs[i].addr, 9'(i), vecs[i].wd);
      chk($sformatf("vec%0d hit", i), 64'(hs), 64'(vecs[i].hit));
      chk($sformatf("vec%0d rsp_valid", i), 64'(rv), 64'(vecs[i].rsp));
      if (vecs[i].rsp) begin
        chk($sformatf("vec%0d rsp_data", i), rdat, vecs[i].exp);
        chk($sformatf("vec%0d rsp_tid", i), 64'(rt), 64'(9'(i)));
      end
    end

    // Reset arriving while a response is pending, and in the same cycle as a read.
    step(1'b1, 1'b0, A_THR, 9'h0, 64'd5);
    step(1'b1, 1'b0, A_DATA, 9'h0, 64'h99);
    step(1'b0, 1'b1, A_STAT, 9'h1A5, 64'h0);
    chk("pre-reset rsp_valid", 64'(rv), 64'h1);
    chk("pre-reset rsp_tid", 64'(rt), 64'h1A5);
    rst_n = 1'b0;
    step(1'b0, 1'b0, 16'h0, 9'h0, 64'h0);
    rst_n = 1'b1;
    chk("post-reset rsp_tid", 64'(rt), 64'h0);
    chk("post-reset rsp_data", rdat, 64'h0);
    step(1'b0, 1'b1, A_THR, 9'h3, 64'h0);
    chk("post-reset thresh valid", 64'(rv), 64'h1);
    chk("post-reset thresh", rdat, 64'd15);
    rst_n = 1'b0;
    step(1'b0, 1'b1, A_STAT, 9'h4, 64'h0);
    rst_n = 1'b1;
    chk("read during reset rsp_valid", 64'(rv), 64'h0);
    step(1'b0, 1'b1, A_STAT, 9'h5, 64'h0);
    chk("post-reset status", rdat, 64'hF1F0_0000_0000_0001);
    chk("post-reset almost_full", 64'(almost_full), 64'h0);

    // Random traffic against the model, alternating push-heavy and pop-heavy phases.
    do_reset();
    model_reset();
    for (int n = 0; n < 800; n++) begin
      int          r;
      logic        wr, rd, push_bias;
      logic [15:0] a;
      logic [63:0] wd;
      logic [8:0]  tid;
      r = $urandom_range(0, 99);
      if (r < 55) a = A_DATA;
      else if (r < 63) a = A_CTRL;
      else if (r < 78) a = A_STAT;
      else if (r < 88) a = A_THR;
      else if (r < 94) a = BASE + 16'd1;
      else a = 16'h0030;
      push_bias = ((n / 100) % 2) == 0;
      wr  = $urandom_range(0, 99) < (push_bias ? 70 : 30);
      rd  = $urandom_range(0, 99) < (push_bias ? 30 : 70);
      wd  = {$urandom, $urandom};
      if (a == A_CTRL) wd[0] = ($urandom_range(0, 7) == 0);
      if (a == A_THR) wd = 64'($urandom_range(0, 31));
      tid = 9'($urandom);
      model_step(wr, rd, a, wd, e_rv, e_d, e_hit);
      step(wr, rd, a, tid, wd);
      chk($sformatf("rnd%0d hit", n), 64'(hs), 64'(e_hit));
      chk($sformatf("rnd%0d rsp_valid", n), 64'(rv), 64'(e_rv));
      chk($sformatf("rnd%0d almost_full", n), 64'(almost_full), 64'(m_af));
      if (e_rv) begin
        chk($sformatf("rnd%0d rsp_data", n), rdat, e_d);
        chk($sformatf("rnd%0d rsp_tid", n), 64'(rt), 64'(tid));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/mmio_fifo_ctrl.md
# mmio_fifo_ctrl

MMIO-facing controller that sequences a 64-bit show-ahead FIFO from the host. Host MMIO writes to a data address push entries, host MMIO reads from the same address pop them. Status and control registers expose occupancy, sticky error flags, flush and an almost-full threshold. It sits inside the AFU beside the DFH/AFU-ID responder, which forwards decoded MMIO requests in its address window and muxes this block's read response onto Tx c2.

## Interface
- DEPTH, 16: FIFO entries; power of two, at least 2.
- WIDTH, 64: entry width; at most 64, zero-extended in read data.
- BASE_ADDR, 16'h0020: MMIO word address of DATA. CTRL = BASE+2, STATUS = BASE+4, THRESH = BASE+6.

- clk  in  1  sole clock.
- rst_n  in  1  reset, synchronous, active-low.
- mmio_wr_valid  in  1  MMIO write strobe, one cycle per request.
- mmio_rd_valid  in  1  MMIO read strobe, one cycle per request.
- mmio_addr  in  16  MMIO word address (CCI-P MMIO header address).
- mmio_tid  in  9  read transaction ID.
- mmio_wdata  in  64  write data.
- rsp_valid  out  1  read response strobe; ignored unless mmio_addr hit the window.
- rsp_tid  out  9  echoed TID.
- rsp_data  out  64  read data.
- almost_full  out  1  registered; count >= THRESH.
- hit  out  1  combinational; current request address is in the window.

## Operation
- Window: exactly the four addresses listed. Other addresses cause no state change and no rsp_valid.
- Write DATA:
  - Not full: push mmio_wdata[WIDTH-1:0].
  - Full without a same-cycle pop: drop the data and set sticky OVF.
- Write CTRL:
  - bit0 = flush: pointers and count go to 0.
  - bit1 = clear OVF/UDF.
  - Other bits ignored.
- Write THRESH: bits [$clog2(DEPTH):0], saturating at DEPTH. Writes to STATUS are ignored.
- Read DATA:
  - Not empty: respond with the head entry (zero-extended) and pop it.
  - Empty: respond 64'h0, no pop, set sticky UDF.
- Read STATUS layout:
  - [0] empty, [1] full, [2] OVF, [3] UDF, [4] almost_full.
  - [31:16] count.
  - [63:48] 16'hF1F0.
  - All other bits 0.
- Read CTRL returns 0. Read THRESH returns the threshold, zero-extended.
- Simultaneous rd and wr in the same cycle (allowed):
  - Status is sampled from pre-cycle state.
  - Pop + push when full: both succeed, count unchanged, no OVF.
  - Pop + push when empty: UDF set, push succeeds, response 0.
  - Flush + push: flush wins, push discarded, no OVF.
  - Flush + pop: response carries the pre-flush head, then the FIFO is empty.
  - OVF set + clear in the same cycle: the set wins.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Count is $clog2(DEPTH)+1 bits and never exceeds DEPTH.
- Reset state: rsp_valid 0, rsp_tid 0, rsp_data 0, count 0, empty 1, OVF 0, UDF 0, THRESH = DEPTH-1, almost_full 0. Memory contents are not reset.

## Timing
- Read response latency is exactly 1 cycle: rsp_valid pulses the cycle after mmio_rd_valid, for one cycle, with rsp_tid and rsp_data registered.
- Back-to-back reads on consecutive cycles give consecutive responses. Each pop is visible to the next cycle's request.
- A push is readable by a DATA read in the following cycle.
- almost_full updates the cycle after count changes.
- rst_n low on any edge:
  - Discards any pending response: rsp_valid is 0 in the following cycle.
  - Returns all state to reset values.
- No backpressure: every request completes in its cycle.

## Structure
- Package mmio_fifo_pkg holds:
  - Address offsets: DATA_OFS 0, CTRL_OFS 2, STATUS_OFS 4, THRESH_OFS 6.
  - STATUS bit indices.
  - The 16'hF1F0 signature.
  - CTRL bit indices.
- Sub-module sync_fifo: show-ahead, parameterized DEPTH/WIDTH.
  - Ports: clk, rst_n, push, pop, flush, din, dout, count, full, empty.
  - Handles pointer wrap and simultaneous push/pop internally.
- mmio_fifo_ctrl holds: address decode, sticky flags, THRESH, the response register and the STATUS assembly.

## Test plan
- Reset, then read STATUS -> rsp_data 64'hF1F0_0000_0000_0001, rsp_valid exactly 1 cycle after the request, TID echoed.
- Push 0x11..0x1F, then read THRESH and STATUS:
  - THRESH reads 15.
  - STATUS has almost_full=1 and count=15.
  - One more push gives full=1 and count=16.
  - A 17th push sets OVF and count stays 16.
- 16 DATA reads after the fill -> 0x11..0x20 in order. The 17th read returns 0 and STATUS then shows UDF=1, empty=1. Write CTRL=2 -> flags clear.
- With the FIFO full, same-cycle push 0xAA and pop -> response 0x11, count 16, no OVF. Drain -> last value 0xAA, confirming pointer wrap.
- Three entries queued, same-cycle CTRL flush and DATA read -> response = old head, next STATUS read shows count 0. Same-cycle flush + push leaves the FIFO empty.
- Read issued, rst_n low the next cycle -> no rsp_valid and STATUS returns reset values. Address 0x0030 read -> no rsp_valid, hit=0.
